parity_unit: RTL and testbench



---
 rtl/parity_unit_pkg.sv | 17 +
 rtl/parity_unit_parity_bit_sel.sv | 22 ++
 rtl/parity_unit.sv | 147 ++++++++++++++
 tb/tb_parity_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_unit_pkg.sv
// Shared UART parity types: parity mode encoding and RX parity-check FSM states.
package parity_unit_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10
    } rx_par_state_t;

endpackage

// File: rtl/parity_unit_parity_bit_sel.sv
// Maps an accumulated XOR of the data bits and a parity mode to the parity bit
// that belongs on the wire. Shared by the TX generator and the RX checker.
module parity_bit_sel
    import parity_unit_pkg::*;
(
    input  logic      acc,
    input  par_mode_t mode,
    output logic      par_bit
);

    always_comb begin
        par_bit = acc;
        case (mode)
            PAR_EVEN:  par_bit = acc;
            PAR_ODD:   par_bit = ~acc;
            PAR_MARK:  par_bit = 1'b1;
            PAR_SPACE: par_bit = 1'b0;
            default:   par_bit = acc;
        endcase
    end

endmodule

// File: rtl/parity_unit.sv
// UART parity unit: registered TX parity generation plus a serial RX parity
// checker with per-frame error pulse, sticky flag and saturating error counter.
module parity_unit
    import parity_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     par_en,
    input  logic [1:0]               par_mode,
    input  logic [DATA_WIDTH-1:0]    tx_p_data,
    input  logic                     tx_data_valid,
    input  logic                     tx_load,
    output logic                     tx_par_bit,
    input  logic                     rx_start,
    input  logic                     rx_sample_en,
    input  logic                     rx_bit,
    output logic                     rx_busy,
    output logic                     rx_done,
    output logic                     rx_par_err,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    input  logic                     err_clr
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

    // ---------------- TX: latch word and mode on load ----------------
    logic [DATA_WIDTH-1:0] tx_data_p0;
    par_mode_t             tx_mode_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_p0 <= '0;
            tx_mode_p0 <= PAR_EVEN;
        end else if (tx_load && tx_data_valid) begin
            tx_data_p0 <= tx_p_data;
            tx_mode_p0 <= par_mode_t'(par_mode);
        end
    end

    // Parity depends only on the latched pair, so a live mode change is invisible.
    parity_bit_sel u_tx_sel (
        .acc     (^tx_data_p0),
        .mode    (tx_mode_p0),
        .par_bit (tx_par_bit)
    );

    // ---------------- RX: serial parity check FSM ----------------
    rx_par_state_t    state, state_n;
    logic             acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rx_en_p0, rx_en_n;
    par_mode_t        rx_mode_p0, rx_mode_n;
    logic             done_n, err_n;
    logic             rx_exp_bit;

    parity_bit_sel u_rx_sel (
        .acc     (acc),
        .mode    (rx_mode_p0),
        .par_bit (rx_exp_bit)
    );

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        rx_en_n   = rx_en_p0;
        rx_mode_n = rx_mode_p0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        // A start bit always (re)opens a frame, even mid-frame, to resync on glitches.
        if (rx_start) begin
            state_n   = DATA;
            acc_n     = 1'b0;
            cnt_n     = '0;
            rx_en_n   = par_en;
            rx_mode_n = par_mode_t'(par_mode);
        end else begin
            case (state)
                DATA: begin
                    if (rx_sample_en) begin
                        acc_n = acc ^ rx_bit;
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt == LAST_BIT) begin
                            if (rx_en_p0) begin
                                state_n = PARITY;
                            end else begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (rx_sample_en) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        err_n   = (rx_bit != rx_exp_bit);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            rx_en_p0   <= 1'b0;
            rx_mode_p0 <= PAR_EVEN;
            rx_done    <= 1'b0;
            rx_par_err <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            rx_en_p0   <= rx_en_n;
            rx_mode_p0 <= rx_mode_n;
            rx_done    <= done_n;
            rx_par_err <= err_n;
            // A coincident clear is applied first, then the new error counts.
            if (err_n) begin
                err_sticky <= 1'b1;
                if (err_clr) begin
                    err_cnt <= ERR_CNT_WIDTH'(1);
                end else if (err_cnt != ERR_CNT_MAX) begin
                    err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                end
            end else if (err_clr) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_parity_unit.sv
// Scoreboard bench for parity_unit: the driver pushes expected results computed
// from a count-of-ones parity model; independent monitors pop and compare.
module tb_parity_unit;

    localparam int DW = 8;
    localparam int EW = 2;
    localparam int CNT_SAT = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          par_en = 1'b0;
    logic [1:0]    par_mode = 2'b00;
    logic [DW-1:0] tx_p_data = '0;
    logic          tx_data_valid = 1'b0;
    logic          tx_load = 1'b0;
    logic          tx_par_bit;
    logic          rx_start = 1'b0;
    logic          rx_sample_en = 1'b0;
    logic          rx_bit = 1'b0;
    logic          rx_busy;
    logic          rx_done;
    logic          rx_par_err;
    logic          err_sticky;
    logic [EW-1:0] err_cnt;
    logic          err_clr = 1'b0;

    parity_unit #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
        .clk(clk), .rst(rst), .par_en(par_en), .par_mode(par_mode),
        .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_load(tx_load),
        .tx_par_bit(tx_par_bit), .rx_start(rx_start), .rx_sample_en(rx_sample_en),
        .rx_bit(rx_bit), .rx_busy(rx_busy), .rx_done(rx_done), .rx_par_err(rx_par_err),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        bit sticky;
        int cnt;
    } rx_exp_t;

    int      checks = 0;
    int      errors = 0;
    rx_exp_t rx_q[$];
    bit      tx_q[$];
    bit      tx_model = 1'b0;
    int      m_cnt = 0;
    bit      m_sticky = 1'b0;
    rx_exp_t mon_e;

    // Parity the wire should carry, from the number of ones in the word.
    function automatic bit ref_par(logic [DW-1:0] d, logic [1:0] m);
        int ones;
        ones = $countones(d);
        if (m == 2'b00) return (ones % 2) == 1;
        if (m == 2'b01) return (ones % 2) == 0;
        if (m == 2'b10) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // TX monitor: adopt the next expected parity whenever a load is accepted.
    always @(posedge clk) begin
        if (rst) begin
            tx_model = 1'b0;
        end else if (tx_load && tx_data_valid) begin
            if (tx_q.size() == 0) check("tx_q_underflow", 0, 1);
            else tx_model = tx_q.pop_front();
        end
    end

    always @(negedge clk) begin
        check("tx_par_bit", int'(tx_par_bit), int'(tx_model));
        if (rx_done) begin
            if (rx_q.size() == 0) begin
                check("rx_unexpected_done", 1, 0);
            end else begin
                mon_e = rx_q.pop_front();
                check("rx_par_err", int'(rx_par_err), int'(mon_e.err));
                check("err_sticky", int'(err_sticky), int'(mon_e.sticky));
                check("err_cnt", int'(err_cnt), mon_e.cnt);
                check("rx_busy_at_done", int'(rx_busy), 0);
            end
        end else begin
            check("rx_par_err_without_done", int'(rx_par_err), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_load_word(logic [DW-1:0] d, logic [1:0] m, bit v);
        tx_p_data     = d;
        par_mode      = m;
        tx_data_valid = v;
        tx_load       = 1'b1;
        if (v) tx_q.push_back(ref_par(d, m));
        tick();
        tx_load       = 1'b0;
        tx_data_valid = 1'b0;
    endtask

    task automatic push_rx(bit err);
        rx_exp_t x;
        x.err    = err;
        x.sticky = m_sticky;
        x.cnt    = m_cnt;
        rx_q.push_back(x);
    endtask

    task automatic gap(bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_sample_en = 1'b0;
                rx_bit       = 1'($urandom);
                par_en       = 1'($urandom);
                par_mode     = 2'($urandom);
                tick();
            end
        end
    endtask

    // abort_after < DW stops the frame after that many data bits (no result expected).
    task automatic rx_frame(logic [DW-1:0] d, bit en, logic [1:0] m, bit pbit,
                            bit clr, int abort_after, bit gaps);
        bit err;
        par_en   = en;
        par_mode = m;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        check("rx_busy_after_start", int'(rx_busy), 1);
        for (int i = 0; i < DW; i++) begin
            if (i == abort_after) begin
                rx_sample_en = 1'b0;
                return;
            end
            gap(gaps);
            rx_sample_en = 1'b1;
            rx_bit       = d[i];
            if (!en && i == DW - 1) push_rx(1'b0);
            tick();
        end
        rx_sample_en = 1'b0;
        if (en) begin
            gap(gaps);
            rx_sample_en = 1'b1;
            rx_bit       = pbit;
            err_clr      = clr;
            err          = (pbit != ref_par(d, m));
            if (clr) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end
            if (err) begin
                m_sticky = 1'b1;
                if (m_cnt < CNT_SAT) m_cnt++;
            end
            push_rx(err);
            tick();
            rx_sample_en = 1'b0;
            err_clr      = 1'b0;
        end
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        m_cnt    = 0;
        m_sticky = 1'b0;
        check("err_cnt_after_clr", int'(err_cnt), 0);
        check("err_sticky_after_clr", int'(err_sticky), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        check("rst_tx_par_bit", int'(tx_par_bit), 0);
        check("rst_rx_busy", int'(rx_busy), 0);
        check("rst_rx_done", int'(rx_done), 0);
        check("rst_rx_par_err", int'(rx_par_err), 0);
        check("rst_err_sticky", int'(err_sticky), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        tick();
        rst = 1'b0;
        tick();

        // TX: 0xA5 has four ones.
        tx_load_word(8'hA5, 2'b00, 1'b1); check("tx_a5_even", int'(tx_par_bit), 0);
        tx_load_word(8'hA5, 2'b01, 1'b1); check("tx_a5_odd", int'(tx_par_bit), 1);
        tx_load_word(8'hA5, 2'b10, 1'b1); check("tx_a5_mark", int'(tx_par_bit), 1);
        tx_load_word(8'hA5, 2'b11, 1'b1); check("tx_a5_space", int'(tx_par_bit), 0);
        par_mode = 2'b10;
        repeat (3) tick();
        check("tx_mode_change_no_load", int'(tx_par_bit), 0);
        tx_load_word(8'h01, 2'b10, 1'b0);
        check("tx_load_without_valid", int'(tx_par_bit), 0);
        for (int i = 0; i < 20; i++) begin
            tx_load_word(DW'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1) begin
                par_mode = 2'($urandom);
                tick();
            end
        end

        // RX good even frame, then odd frame 0x03 with parity 0 (two ones need 1).
        rx_frame(8'h01, 1'b1, 2'b00, 1'b1, 1'b0, DW, 1'b0);
        rx_frame(8'h03, 1'b1, 2'b01, 1'b0, 1'b0, DW, 1'b0);
        tick();
        check("bad_frame_sticky", int'(err_sticky), 1);
        check("bad_frame_cnt", int'(err_cnt), 1);

        // Saturation and clear coincident with an error.
        clear_errors();
        repeat (5) rx_frame(8'h03, 1'b1, 2'b01, 1'b0, 1'b0, DW, 1'b0);
        tick();
        check("err_cnt_saturated", int'(err_cnt), CNT_SAT);
        rx_frame(8'h03, 1'b1, 2'b01, 1'b0, 1'b1, DW, 1'b0);
        tick();
        check("clr_with_error_cnt", int'(err_cnt), 1);
        check("clr_with_error_sticky", int'(err_sticky), 1);

        // Parity disabled, configuration inputs toggled during the frame.
        rx_frame(8'hC3, 1'b0, 2'b00, 1'b0, 1'b0, DW, 1'b1);
        tick();

        // Abort after four bits, restart; result only after a full new frame.
        rx_frame(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 4, 1'b0);
        rx_frame(8'h5A, 1'b1, 2'b00, 1'b1, 1'b0, DW, 1'b0);
        tick();

        // Reset in the middle of a frame.
        rx_frame(8'h0F, 1'b1, 2'b00, 1'b0, 1'b0, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        m_cnt    = 0;
        m_sticky = 1'b0;
        check("rst_mid_frame_busy", int'(rx_busy), 0);
        check("rst_mid_frame_cnt", int'(err_cnt), 0);
        check("rst_mid_frame_sticky", int'(err_sticky), 0);
        repeat (12) tick();

        // Random frames, mostly back-to-back.
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            logic [1:0]    m;
            bit            en;
            d  = DW'($urandom);
            m  = 2'($urandom);
            en = 1'($urandom_range(0, 3) != 0);
            rx_frame(d, en, m, ref_par(d, m) ^ 1'($urandom), $urandom_range(0, 3) == 0,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DW - 1)) : DW,
                     1'($urandom));
            if ($urandom_range(0, 7) == 0) clear_errors();
            if ($urandom_range(0, 3) == 0) tx_load_word(DW'($urandom), 2'($urandom), 1'b1);
        end

        repeat (5) tick();
        check("rx_q_drained", rx_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
